pipe_hazard_ctl: RTL
====================

Name: pipe_hazard_ctl

Overview:
- Central pipeline controller for the 5-stage RV32I core; drives hold/clear into fetch, decode and execute.
- Resolves operand forwarding into execute and inserts load-use bubbles.
- Holds the pipe while the data bus handshake is outstanding; times out to a bus error if it never completes.
- Sequences the PC redirect and wrong-path flush after a taken jump/branch/fence.

Parameters:
- MEM_TIMEOUT, 16: max cycles waiting for mem_ack before bus_err; range 1..255.
- FLUSH_CYCLES, 2: cycles clear_dec stays asserted after a redirect; matches imem fetch latency; range 1..15.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- rs1_addr_dec  in  5  decode-stage rs1 index
- rs1_ren_dec  in  1  decode instruction reads rs1
- rs2_addr_dec  in  5  decode-stage rs2 index
- rs2_ren_dec  in  1  decode instruction reads rs2
- rf_rdata1  in  32  register-file rs1 data
- rf_rdata2  in  32  register-file rs2 data
- reg_wen_exe  in  1  execute-output write enable
- reg_waddr_exe  in  5  execute-output rd
- reg_wdata_exe  in  32  execute-output result
- load_exe  in  1  OR of lb/lh/lbu/lhu/lw at execute output
- store_exe  in  1  OR of sb/sh/sw at execute output
- reg_wen_mem  in  1  mem-stage write enable
- reg_waddr_mem  in  5  mem-stage rd
- reg_wdata_mem  in  32  mem-stage result, load data included
- mem_ack  in  1  data-bus completion, 1-cycle pulse
- jump_en_exe  in  1  registered taken-jump flag
- jump_addr_exe  in  32  registered jump target
- reg_rdata1_ctl  out  32  forwarded rs1 operand to execute
- reg_rdata2_ctl  out  32  forwarded rs2 operand to execute
- hold_if  out  1  freeze PC/fetch
- hold_dec  out  1  freeze decode register
- hold_exe  out  1  hold_ctl to execute
- clear_dec  out  1  bubble decode register
- clear_exe  out  1  clear_ctl to execute
- pc_redirect_en  out  1  load PC with pc_redirect_addr
- pc_redirect_addr  out  32  redirect target
- bus_err  out  1  1-cycle pulse on mem timeout
- stall_cnt  out  32  performance counter (optional feature)
- flush_cnt  out  32  performance counter (optional feature)

Behaviour:
- Forwarding is combinational, per operand, first match wins:
  - index 0 → 0.
  - reg_wen_exe & !load_exe & waddr match → reg_wdata_exe.
  - reg_wen_mem & waddr match → reg_wdata_mem.
  - otherwise rf_rdata.
- Load-use hazard: load_exe & reg_wen_exe & reg_waddr_exe≠0 & ((rs1_ren_dec & rs1 match) | (rs2_ren_dec & rs2 match)).
- FSM states:
  - RUN: reset state.
  - MWAIT
  - REDIR
- RUN, same-cycle outputs, priority order:
  1. (load_exe|store_exe) & !mem_ack → hold_if=hold_dec=hold_exe=1; counter loaded with 1; next state MWAIT.
  2. jump_en_exe → pc_redirect_en=1, pc_redirect_addr=jump_addr_exe, clear_dec=clear_exe=1; counter loaded with 1; next state REDIR if FLUSH_CYCLES>1, else RUN.
  3. Load-use hazard → hold_if=hold_dec=1, clear_exe=1, hold_exe=0 (one bubble); stay RUN. The next cycle the load is in mem and forwards from the mem port.
- MWAIT:
  - Holds all three stages every cycle.
  - mem_ack=1 → release in that cycle (all holds 0); return to RUN.
  - Counter==MEM_TIMEOUT with no ack → bus_err=1 for 1 cycle, holds released, return to RUN.
  - Otherwise counter increments.
  - jump_en_exe and the load-use check are ignored while in MWAIT.
- REDIR:
  - clear_dec=1, hold all 0, pc_redirect_en=0, counter increments.
  - Counter reaches FLUSH_CYCLES-1 → return to RUN.
  - A new jump_en_exe here restarts redirect: outputs as RUN step 2, counter reset to 1.
- Precedence: hold has priority over clear in the execute stage, so clear_exe is never asserted together with hold_exe.
- Reset (rst=1 at clk edge):
  - State RUN, counter 0.
  - All registered outputs 0; bus_err 0; counters 0.
  - Forwarding outputs remain combinational.
  - Reset mid-MWAIT or mid-REDIR aborts with no bus_err.
- Counter: 8-bit, saturating, never wraps.

Optional Feature:
- Macro PIPE_HAZARD_PERF_EN.
- Defined:
  - stall_cnt +1 on every cycle with hold_if=1.
  - flush_cnt +1 on every pc_redirect_en=1.
  - Both 32-bit, wrap from 0xFFFFFFFF to 0, cleared by rst.
- Undefined: stall_cnt and flush_cnt tied to 0 with no registers.

Test Plan:
- x5 written in exe (reg_wdata_exe=0x1234, not load), decode reads rs1=x5 → reg_rdata1_ctl=0x1234 same cycle; rs1=x0 with rd=x0 in exe → 0.
- lw x7 in exe, decode add x8,x7,x7 → 1 cycle hold_if=hold_dec=clear_exe=1, hold_exe=0; next cycle reg_wdata_mem=0xDEAD forwarded on both operands, no holds.
- load_exe=1, mem_ack arrives on the 4th cycle → holds high for 4 cycles, release in the ack cycle, bus_err=0.
- MEM_TIMEOUT=16, ack never arrives → bus_err pulse on cycle 16, holds drop same cycle, state RUN.
- jump_en_exe=1, jump_addr_exe=0x80000040, FLUSH_CYCLES=2 → cycle0 redirect 0x80000040 with clear_dec=clear_exe=1; cycle1 clear_dec=1 only; cycle2 all 0; with PIPE_HAZARD_PERF_EN, flush_cnt=1.
- rst asserted during cycle 3 of MWAIT → next cycle all holds 0, bus_err never pulses, stall_cnt=0.

Source files
------------

// File: rtl/pipe_hazard_ctl.sv
// pipe_hazard_ctl -- central hazard / flow controller for the 5-stage RV32I core.
//
// Purpose:
//   - Forwards execute/mem results onto the two decode operands that are
//     handed to execute (combinational, exe result has priority over mem).
//   - Inserts a single bubble on a load-use hazard.
//   - Freezes fetch/decode/execute while a data-bus access is outstanding;
//     raises a one-cycle bus_err if mem_ack does not arrive in MEM_TIMEOUT cycles.
//   - Redirects the PC on a taken jump/branch/fence and flushes the wrong path
//     for FLUSH_CYCLES cycles.
//
// Optional feature:
//   `define PIPE_HAZARD_PERF_EN to build the stall/flush performance counters.
//   Without it, stall_cnt and flush_cnt are constant 0 and no registers exist.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   rs1_*/rs2_* _dec                  decode-stage source indices and read enables
//   rf_rdata1/2                       register-file read data
//   reg_wen/waddr/wdata_exe, load_exe, store_exe   execute-output writeback info
//   reg_wen/waddr/wdata_mem           mem-stage writeback info
//   mem_ack                           data-bus completion pulse
//   jump_en_exe, jump_addr_exe        registered taken-jump flag and target
//   reg_rdata1/2_ctl                  forwarded operands to execute
//   hold_if/dec/exe, clear_dec/exe    stage hold and bubble controls
//   pc_redirect_en/addr               PC load request
//   bus_err                           one-cycle pulse on data-bus timeout
//   stall_cnt, flush_cnt              performance counters (optional)

module pipe_hazard_ctl #(
  parameter int MEM_TIMEOUT  = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_addr_dec,
  input  logic        rs1_ren_dec,
  input  logic [4:0]  rs2_addr_dec,
  input  logic        rs2_ren_dec,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  input  logic        reg_wen_exe,
  input  logic [4:0]  reg_waddr_exe,
  input  logic [31:0] reg_wdata_exe,
  input  logic        load_exe,
  input  logic        store_exe,
  input  logic        reg_wen_mem,
  input  logic [4:0]  reg_waddr_mem,
  input  logic [31:0] reg_wdata_mem,
  input  logic        mem_ack,
  input  logic        jump_en_exe,
  input  logic [31:0] jump_addr_exe,
  output logic [31:0] reg_rdata1_ctl,
  output logic [31:0] reg_rdata2_ctl,
  output logic        hold_if,
  output logic        hold_dec,
  output logic        hold_exe,
  output logic        clear_dec,
  output logic        clear_exe,
  output logic        pc_redirect_en,
  output logic [31:0] pc_redirect_addr,
  output logic        bus_err,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam logic [7:0] TIMEOUT_C    = 8'(MEM_TIMEOUT);
  localparam logic [7:0] FLUSH_LAST_C = 8'(FLUSH_CYCLES - 1);
  localparam bit         FLUSH_MULTI  = (FLUSH_CYCLES > 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MWAIT = 2'd1,
    ST_REDIR = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;

  // ---------------------------------------------------------------------------
  // Operand forwarding and per-operand load-use match
  // ---------------------------------------------------------------------------
  logic [1:0][4:0]  rs_addr;
  logic [1:0]       rs_ren;
  logic [1:0][31:0] rf_rdata;
  logic [1:0][31:0] fwd_data;
  logic [1:0]       rs_load_hit;

  assign rs_addr  = {rs2_addr_dec, rs1_addr_dec};
  assign rs_ren   = {rs2_ren_dec, rs1_ren_dec};
  assign rf_rdata = {rf_rdata2, rf_rdata1};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_operand
      // A load's exe-stage result is only an address, so it must not forward;
      // the data shows up one cycle later on the mem port.
      assign fwd_data[gi] =
        (rs_addr[gi] == 5'd0)                                          ? 32'd0 :
        (reg_wen_exe && !load_exe && (reg_waddr_exe == rs_addr[gi]))   ? reg_wdata_exe :
        (reg_wen_mem && (reg_waddr_mem == rs_addr[gi]))                ? reg_wdata_mem :
                                                                         rf_rdata[gi];
      assign rs_load_hit[gi] = rs_ren[gi] && (reg_waddr_exe == rs_addr[gi]);
    end
  endgenerate

  assign reg_rdata1_ctl = fwd_data[0];
  assign reg_rdata2_ctl = fwd_data[1];

  logic load_use;
  assign load_use = load_exe && reg_wen_exe && (reg_waddr_exe != 5'd0) && (|rs_load_hit);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_RUN;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  logic hold_if_c, hold_dec_c, hold_exe_c, clear_dec_c, clear_exe_c;
  logic redirect_c, bus_err_c;

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    hold_if_c   = 1'b0;
    hold_dec_c  = 1'b0;
    hold_exe_c  = 1'b0;
    clear_dec_c = 1'b0;
    clear_exe_c = 1'b0;
    redirect_c  = 1'b0;
    bus_err_c   = 1'b0;

    case (state_reg)
      ST_RUN: begin
        if ((load_exe || store_exe) && !mem_ack) begin
          hold_if_c  = 1'b1;
          hold_dec_c = 1'b1;
          hold_exe_c = 1'b1;
          cnt_next   = 8'd1;
          state_next = ST_MWAIT;
        end else if (jump_en_exe) begin
          redirect_c  = 1'b1;
          clear_dec_c = 1'b1;
          clear_exe_c = 1'b1;
          cnt_next    = 8'd1;
          state_next  = FLUSH_MULTI ? ST_REDIR : ST_RUN;
        end else if (load_use) begin
          // One bubble: freeze the consumer in decode, feed execute a NOP.
          hold_if_c   = 1'b1;
          hold_dec_c  = 1'b1;
          clear_exe_c = 1'b1;
        end
      end

      ST_MWAIT: begin
        if (mem_ack) begin
          state_next = ST_RUN;
        end else if (cnt_reg >= TIMEOUT_C) begin
          bus_err_c  = 1'b1;
          state_next = ST_RUN;
        end else begin
          hold_if_c  = 1'b1;
          hold_dec_c = 1'b1;
          hold_exe_c = 1'b1;
          cnt_next   = sat_inc(cnt_reg);
        end
      end

      ST_REDIR: begin
        clear_dec_c = 1'b1;
        if (jump_en_exe) begin
          // A younger taken jump restarts the flush window from its own target.
          redirect_c  = 1'b1;
          clear_exe_c = 1'b1;
          cnt_next    = 8'd1;
        end else begin
          cnt_next = sat_inc(cnt_reg);
          if (cnt_reg >= FLUSH_LAST_C) begin
            state_next = ST_RUN;
          end
        end
      end

      default: begin
        state_next = ST_RUN;
        cnt_next   = 8'd0;
      end
    endcase
  end

  assign hold_if          = hold_if_c;
  assign hold_dec         = hold_dec_c;
  assign hold_exe         = hold_exe_c;
  assign clear_dec        = clear_dec_c;
  // A held execute register keeps its instruction; never bubble it at the same time.
  assign clear_exe        = clear_exe_c && !hold_exe_c;
  assign pc_redirect_en   = redirect_c;
  assign pc_redirect_addr = redirect_c ? jump_addr_exe : 32'd0;
  // A reset that lands on the timeout cycle aborts the wait silently.
  assign bus_err          = bus_err_c && !rst;

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] flush_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= 32'd0;
      flush_cnt_reg <= 32'd0;
    end else begin
      stall_cnt_reg <= stall_cnt_reg + 32'(hold_if_c);
      flush_cnt_reg <= flush_cnt_reg + 32'(redirect_c);
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule
